// File: rtl/fifo_pkg.sv
// Shared types and constants for sync_fifo and its read-side engine.
// Output buffer state encoding doubles as its occupancy count.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH      = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // True when a new pop this cycle still fits once everything lands.
  function automatic logic has_credit(
    input logic [1:0] level,
    input logic       inflight,
    input logic       acc
  );
    logic [2:0] used;
    logic [2:0] cap;
    used = {1'b0, level} + {2'b0, inflight};
    cap  = 3'(BUF_DEPTH) + {2'b0, acc};
    return used < cap;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register buffer; d0 is always the oldest word.
// Simultaneous push and pop in ONE replaces the head on the same edge.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [1:0]            level
);

  buf_state_e            state_q;
  buf_state_e            state_d;
  logic [DATA_WIDTH-1:0] d0_q;
  logic [DATA_WIDTH-1:0] d1_q;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= BUF_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy from push/pop; clear wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_TWO;
        else if (pop && !push) state_d = BUF_EMPTY;
      end
      BUF_TWO: if (pop && !push) state_d = BUF_ONE;
      default: state_d = BUF_EMPTY;
    endcase
    if (clear) state_d = BUF_EMPTY;
  end

  // Data slots: fill head first, shift tail forward on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (!clear) begin
      if (push) begin
        if (state_q == BUF_EMPTY || (state_q == BUF_ONE && pop)) begin
          d0_q <= din;
        end else if (state_q == BUF_ONE) begin
          d1_q <= din;
        end else begin
          d0_q <= d1_q;
          d1_q <= din;
        end
      end else if (pop && state_q == BUF_TWO) begin
        d0_q <= d1_q;
      end
    end
  end

  // Credit logic upstream must never land a word into a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && state_q == BUF_TWO));
  end

  assign dout  = d0_q;
  assign valid = (state_q != BUF_EMPTY);
  assign level = state_q;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side engine for sync_fifo: pops words and streams them out
// over valid/ready, hiding the one-cycle FIFO read latency.
module sync_fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_level,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  logic inflight_q;
  logic accept;

  assign accept = m_valid & m_ready;

  assign fifo_rd_en = ~fifo_empty & ~flush & ~rst &
                      has_credit(buf_level, inflight_q, accept);

  // A pop accepted this cycle delivers its data next cycle.
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= fifo_rd_en & ~fifo_empty;
  end

  // Delivered-word counter; survives flush, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         pop_count <= '0;
    else if (accept) pop_count <= pop_count + CNT_WIDTH'(1);
  end

  // A word landing on the flush edge is dropped, not pushed.
  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (inflight_q & ~flush),
    .din  (fifo_rd_data),
    .pop  (accept),
    .dout (m_data),
    .valid(m_valid),
    .level(buf_level)
  );

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Directed bench for sync_fifo_stream_reader with a behavioural FIFO.
// A second instance with a 3-bit counter covers counter wrap.
module tb_sync_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        m_ready;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data = '0;

  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  buf_level;
  logic [15:0] pop_count;

  logic        w_rd_en;
  logic        w_valid;
  logic [7:0]  w_data;
  logic [1:0]  w_level;
  logic [2:0]  w_count;

  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [7:0]  got [0:63];
  int          ng = 0;

  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .buf_level(buf_level), .pop_count(pop_count)
  );

  sync_fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_rd_en(w_rd_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .m_valid(w_valid), .m_ready(m_ready), .m_data(w_data),
    .buf_level(w_level), .pop_count(w_count)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (ng < 64) got[ng] = m_data;
      ng++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  initial begin
    logic [7:0] e;
    logic       prev_stall;
    logic [7:0] prev_data;

    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;

    // Reset with 3 words waiting
    load(8'h11); load(8'h22); load(8'h33);
    tick(); tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_count", 32'(pop_count), 32'd0);
    chk("rst_level", 32'(buf_level), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);

    // Full-rate stream of 8 words
    load(8'h44); load(8'h55); load(8'h66); load(8'h77); load(8'h88);
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("lat_rd_en", 32'(fifo_rd_en), 32'd1);
    chk("lat_v0", 32'(m_valid), 32'd0);
    tick();
    chk("lat_v1", 32'(m_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      e = 8'((k + 1) * 17);
      chk("stream_valid", 32'(m_valid), 32'd1);
      chk("stream_data", 32'(m_data), 32'(e));
    end
    tick();
    chk("stream_idle", 32'(m_valid), 32'd0);
    chk("stream_count", 32'(pop_count), 32'd8);
    chk("stream_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("wrap_count_8", 32'(w_count), 32'd0);
    chk("stream_ng", 32'(ng), 32'd8);
    for (int k = 0; k < 8; k++) begin
      e = 8'((k + 1) * 17);
      chk("stream_log", 32'(got[k]), 32'(e));
    end

    // Back-pressure with 5 words
    m_ready = 1'b0;
    load(8'hA0); load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    tick(); tick(); tick(); tick();
    chk("bp_level", 32'(buf_level), 32'd2);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("bp_fifo_left", 32'(wr_ptr - rd_ptr), 32'd3);
    chk("bp_head", 32'(m_data), 32'hA0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("bp_ng", 32'(ng), 32'd13);
    for (int j = 0; j < 5; j++) begin
      e = 8'(8'hA0 + j);
      chk("bp_order", 32'(got[8 + j]), 32'(e));
    end
    chk("bp_count", 32'(pop_count), 32'd13);
    chk("bp_level_end", 32'(buf_level), 32'd0);
    chk("wrap_count_13", 32'(w_count), 32'd5);

    // Toggling ready over 10 words
    m_ready = 1'b0;
    for (int j = 0; j < 10; j++) load(8'(8'hB0 + j));
    prev_stall = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev_stall) begin
        chk("tog_hold_valid", 32'(m_valid), 32'd1);
        chk("tog_hold_data", 32'(m_data), 32'(prev_data));
      end
      m_ready = (i % 2 == 0);
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
    chk("tog_ng", 32'(ng), 32'd23);
    for (int j = 0; j < 10; j++) begin
      e = 8'(8'hB0 + j);
      chk("tog_order", 32'(got[13 + j]), 32'(e));
    end
    chk("tog_level_end", 32'(buf_level), 32'd0);

    // Flush with a full buffer draining and a word in flight
    m_ready = 1'b0;
    tick();
    load(8'hC0); load(8'hC1); load(8'hC2); load(8'hC3);
    #1;
    chk("fl_rd_en0", 32'(fifo_rd_en), 32'd1);
    tick(); tick(); tick();
    chk("fl_level2", 32'(buf_level), 32'd2);
    chk("fl_head", 32'(m_data), 32'hC0);
    chk("fl_rd_en_full", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    #1;
    chk("fl_rd_en_credit", 32'(fifo_rd_en), 32'd1);
    tick();
    chk("fl_level1", 32'(buf_level), 32'd1);
    chk("fl_head2", 32'(m_data), 32'hC1);
    flush = 1'b1;
    #1;
    chk("fl_rd_en_flush", 32'(fifo_rd_en), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_level0", 32'(buf_level), 32'd0);
    chk("fl_count", 32'(pop_count), 32'd25);
    repeat (6) tick();
    chk("fl_ng", 32'(ng), 32'd26);
    chk("fl_log0", 32'(got[23]), 32'hC0);
    chk("fl_log1", 32'(got[24]), 32'hC1);
    chk("fl_log2", 32'(got[25]), 32'hC3);
    chk("fl_count_end", 32'(pop_count), 32'd26);
    chk("wrap_count_26", 32'(w_count), 32'd2);
    chk("fl_fifo_empty", 32'(fifo_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
